seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scheduler that shares one active-low 7-segment bus {a..g} between DIGITS common-anode digits. It sits between the FSM/datapath blocks that produce hex values and the board's display pins. Each digit gets a fixed drive slot followed by a blanking gap to prevent ghosting. New display words are accepted through a load handshake and applied only at frame boundaries, so the display never tears.

## Interface
- DIGITS, 4: number of multiplexed digits (2..8)
- TICK_DIV, 50000: clk cycles each digit is driven per slot (≥2)
- BLANK_CYC, 16: clk cycles all digits are off between slots (≥1)
- clk  in  1  system clock (Sys_Clk0 domain); one clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  request to accept load_data this cycle
- load_data  in  4*DIGITS  hex nibbles; nibble i ([4i+3:4i]) shows on digit i
- load_ready  out  1  high when a load will be accepted
- seg  out  7  {a,b,c,d,e,f,g}, active-low (0 = lit)
- an  out  DIGITS  digit enables, active-low, at most one low at a time
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: state {BLANK, DRIVE}, idx (digit index), cnt (slot counter), shadow (displayed word), pending + pend_valid.
- Reset: state=BLANK, idx=DIGITS-1, cnt=0, shadow=0, pend_valid=0. Outputs: seg=7'b1111111, an=all 1, load_ready=1, frame_done=0.
- BLANK: seg=all 1, an=all 1. When cnt reaches BLANK_CYC-1: cnt←0, state←DRIVE, idx←(idx==DIGITS-1)?0:idx+1.
- DRIVE: an = all 1 except bit idx = 0; seg = decode(shadow nibble idx). When cnt reaches TICK_DIV-1: cnt←0, state←BLANK.
- Frame boundary is the BLANK→DRIVE transition where idx wraps DIGITS-1→0. At that transition: if pend_valid, shadow←pending and pend_valid←0; frame_done=1 for the first DRIVE cycle of digit 0.
- Handshake: load_ready = !pend_valid. A load with load_ready=1 captures pending←load_data and sets pend_valid. A load with load_ready=0 is ignored and is not queued.
- Simultaneous load and boundary: the transfer uses the old pending. If pend_valid was 0, the new load is captured into pending and applied at the next boundary. It never bypasses into shadow.
- Decode: active-low, with 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Mid-operation reset: the next edge forces the full reset state. shadow and pending are cleared, and the display restarts blank.

## Timing
- All outputs are registered. They reflect the state after each clk edge, with no combinational path from load to any output.
- Cycle 0 is the first edge with rst=0. Cycles 0..BLANK_CYC-1 are blank. Digit 0 is driven from cycle BLANK_CYC for TICK_DIV cycles. frame_done is high in cycle BLANK_CYC only.
- Slot period = TICK_DIV+BLANK_CYC. Frame period = DIGITS*(TICK_DIV+BLANK_CYC). frame_done period equals the frame period exactly.
- load_ready falls in the cycle after an accepted load. It rises in the cycle after the boundary that consumes the pending word.
- Latency from load to visible digits is ≤ one frame period + BLANK_CYC.
- Counter width is clog2(max(TICK_DIV, BLANK_CYC)). cnt never exceeds the slot terminal value.

## Structure
- seg_pkg: SEG_BLANK = 7'b1111111, hex-to-seg constant table/function, state enum {BLANK, DRIVE}.
- One sub-module, seg_hex_decode: 4-bit in, 7-bit active-low out, purely combinational. It is instantiated once on the nibble muxed by idx.
- Prescaler, FSM, handshake and shadow registers live in seg_scan_ctrl.

## Test plan
Bench parameters: DIGITS=4, TICK_DIV=8, BLANK_CYC=2 (slot period 10, frame period 40).
- Reset release, no load -> cycles 0–1 seg=7F, an=F. Cycle 2: an=1110, seg=0000001, frame_done=1. Cycle 12: an=1101. frame_done pulses at cycles 2, 42, 82.
- Load 16'h4321 at cycle 5 -> load_ready=0 from cycle 6. At cycle 42 digits 0..3 show 1001111, 0010010, 0000110, 1001100. load_ready=1 at cycle 43.
- Load 16'hBEEF while pend_valid=1 -> ignored. The display shows only the first word after the next boundary.
- Load 16'hA5C0 asserted in the boundary cycle with pend_valid=0 -> not shown in that frame. It appears at the following frame_done.
- rst pulsed mid-DRIVE of digit 2 -> the next cycle has seg=7F, an=F, load_ready=1, and shadow reads 0 on the next frame. Timing restarts as in the first scenario.
- All 16 nibble values cycled through digit 0 -> seg matches the decode list. Across the whole run, an never has more than one bit low, and seg=7F whenever an=all 1.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, scan states and hex decode table for the 7-segment scanner
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_e;

  // Active-low {a,b,c,d,e,f,g}; lower-case glyphs for b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to active-low 7-segment pattern
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed digit scanner with blanking gaps and frame-aligned word loads
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_e               state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]    shadow_q, shadow_d;
  logic [DIGITS-1:0][3:0]    pending_q, pending_d;
  logic                      pend_valid_q, pend_valid_d;
  logic                      xfer_q, xfer_d;
  logic                      boundary;

  logic [6:0]                seg_q, seg_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic                      frame_done_q;
  logic                      load_ready_q;

  logic [3:0]                nib_d;
  logic [6:0]                dec_seg;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNT_W'(1);
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    xfer_d       = 1'b0;
    boundary     = 1'b0;

    if (state_q == BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        cnt_d   = '0;
        state_d = DRIVE;
        if (idx_q == IDX_LAST) begin
          idx_d    = '0;
          boundary = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end else if (cnt_q == TICK_LAST) begin
      cnt_d   = '0;
      state_d = BLANK;
    end

    if (boundary && pend_valid_q) begin
      shadow_d = pending_q;
      xfer_d   = 1'b1;
    end

    // pend_valid drops one cycle after the copy so load_ready stays low through the frame_done cycle.
    if (xfer_q) begin
      pend_valid_d = 1'b0;
    end else if (load && !pend_valid_q) begin
      pending_d    = load_data;
      pend_valid_d = 1'b1;
    end
  end

  assign nib_d = shadow_d[idx_d];

  seg_hex_decode u_hex_decode (
    .hex_i (nib_d),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (state_d == DRIVE) begin
      an_d[idx_d] = 1'b0;
      seg_d       = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= IDX_LAST;
      cnt_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      xfer_q       <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      xfer_q       <= xfer_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
      load_ready_q <= !pend_valid_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (4 digits, slot 8+2)
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] load_data;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int cyc;
  int total;
  int passed;
  bit mon_en;

  logic [6:0] tbl [16];

  seg_scan_ctrl #(
    .DIGITS    (4),
    .TICK_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_ready (load_ready),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_load(input int n, input logic [15:0] d);
    goto(n);
    load      = 1'b1;
    load_data = d;
    step();
    load      = 1'b0;
    load_data = 16'h0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("an_onehot0", 16'($countones(~an) <= 1), 16'd1);
      if (an === 4'hF) chk("seg_blank_when_off", 16'(seg), 16'h7F);
    end
  end

  initial begin
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    total     = 0;
    passed    = 0;
    mon_en    = 1'b0;
    rst       = 1'b1;
    load      = 1'b0;
    load_data = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cyc    = 0;
    mon_en = 1'b1;

    // Reset release and first frame timing
    chk("c0_seg", 16'(seg), 16'h7F);
    chk("c0_an", 16'(an), 16'hF);
    chk("c0_ready", 16'(load_ready), 16'd1);
    chk("c0_fd", 16'(frame_done), 16'd0);
    goto(1);
    chk("c1_an", 16'(an), 16'hF);
    chk("c1_seg", 16'(seg), 16'h7F);
    goto(2);
    chk("c2_an", 16'(an), 16'b1110);
    chk("c2_seg", 16'(seg), 16'(7'b0000001));
    chk("c2_fd", 16'(frame_done), 16'd1);
    goto(3);
    chk("c3_fd", 16'(frame_done), 16'd0);

    // First word, then a load while pending is full
    do_load(5, 16'h4321);
    chk("c6_ready", 16'(load_ready), 16'd0);
    goto(10);
    chk("c10_an_gap", 16'(an), 16'hF);
    goto(12);
    chk("c12_an", 16'(an), 16'b1101);
    do_load(20, 16'hBEEF);
    goto(32);
    chk("c32_an", 16'(an), 16'b0111);
    chk("c32_seg_old", 16'(seg), 16'(7'b0000001));
    goto(41);
    chk("c41_fd", 16'(frame_done), 16'd0);
    goto(42);
    chk("c42_fd", 16'(frame_done), 16'd1);
    chk("c42_an", 16'(an), 16'b1110);
    chk("c42_seg_d0", 16'(seg), 16'(7'b1001111));
    chk("c42_ready", 16'(load_ready), 16'd0);
    goto(43);
    chk("c43_ready", 16'(load_ready), 16'd1);
    chk("c43_fd", 16'(frame_done), 16'd0);
    goto(52);
    chk("c52_seg_d1", 16'(seg), 16'(7'b0010010));
    goto(62);
    chk("c62_seg_d2", 16'(seg), 16'(7'b0000110));
    goto(72);
    chk("c72_seg_d3", 16'(seg), 16'(7'b1001100));
    chk("c72_an", 16'(an), 16'b0111);

    // Load landing on the frame-boundary edge waits a full frame
    do_load(81, 16'hA5C0);
    chk("c82_fd", 16'(frame_done), 16'd1);
    chk("c82_seg_old", 16'(seg), 16'(7'b1001111));
    chk("c82_ready", 16'(load_ready), 16'd0);
    goto(122);
    chk("c122_fd", 16'(frame_done), 16'd1);
    chk("c122_seg_d0", 16'(seg), 16'(7'b0000001));
    goto(123);
    chk("c123_ready", 16'(load_ready), 16'd1);
    goto(132);
    chk("c132_seg_d1", 16'(seg), 16'(7'b0110001));
    goto(142);
    chk("c142_seg_d2", 16'(seg), 16'(7'b0100100));
    goto(152);
    chk("c152_seg_d3", 16'(seg), 16'(7'b0001000));

    // Every nibble through digit 0
    for (int k = 0; k < 16; k++) begin
      do_load(125 + 40 * k, 16'(k));
      goto(162 + 40 * k);
      chk($sformatf("nib%0d_fd", k), 16'(frame_done), 16'd1);
      chk($sformatf("nib%0d_an", k), 16'(an), 16'b1110);
      chk($sformatf("nib%0d_seg", k), 16'(seg), 16'(tbl[k]));
    end

    // Mid-DRIVE reset with a word still pending
    do_load(770, 16'h1234);
    chk("c771_ready", 16'(load_ready), 16'd0);
    goto(785);
    chk("c785_an_d2", 16'(an), 16'b1011);
    rst = 1'b1;
    step();
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_ready", 16'(load_ready), 16'd1);
    chk("rst_fd", 16'(frame_done), 16'd0);
    rst = 1'b0;
    cyc = 0;
    goto(1);
    chk("r1_an", 16'(an), 16'hF);
    goto(2);
    chk("r2_an", 16'(an), 16'b1110);
    chk("r2_seg", 16'(seg), 16'(7'b0000001));
    chk("r2_fd", 16'(frame_done), 16'd1);
    goto(12);
    chk("r12_an", 16'(an), 16'b1101);
    goto(42);
    chk("r42_fd", 16'(frame_done), 16'd1);
    chk("r42_seg", 16'(seg), 16'(7'b0000001));
    chk("r42_ready", 16'(load_ready), 16'd1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
